extremum_finder_mc: RTL and testbench

Multi-channel, parametrised windowed extremum detector for the vibrometer signal path. It splits each accepted input beat into CHANNEL_COUNT signed lanes and tracks each lane's maximum and minimum over a window of 2^EF_log_count accepted samples. At the end of each window it emits, per lane, either the scaled min/max pair or the peak-to-peak amplitude, on an AXI-Stream master with a one-deep holding register and overflow detection. It sits after the demodulation/filter stage and feeds the register/DMA side with amplitude statistics.

---
 rtl/extremum_finder_mc.sv | 102 ++++++++++
 tb/tb_extremum_finder_mc.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/extremum_finder_mc.sv
// extremum_finder_mc: per-lane windowed min/max or peak-to-peak detector
// feeding a one-deep AXI-Stream holding register with sticky overflow.
module extremum_finder_mc #(
    parameter int CHANNEL_COUNT    = 2,
    parameter int SAMPLE_WIDTH     = 16,
    parameter int AXIS_TDATA_WIDTH = CHANNEL_COUNT * SAMPLE_WIDTH,
    parameter int MAX_LOG_COUNT    = 20
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [4:0]                    EF_log_count,
    input  logic [2:0]                    EF_shift,
    input  logic                          EF_mode,
    input  logic [AXIS_TDATA_WIDTH-1:0]   S_AXIS_tdata,
    input  logic                          S_AXIS_tvalid,
    output logic                          S_AXIS_tready,
    output logic [2*AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
    output logic                          M_AXIS_tvalid,
    input  logic                          M_AXIS_tready,
    output logic                          overflow
);
    localparam int W = SAMPLE_WIDTH;
    localparam logic [MAX_LOG_COUNT:0] one = 1;

    logic [4:0] n_in, log_q;
    logic chg, acc, en, is_first, is_last;
    logic s1_v, s1_first, s1_last, s2_done, load;
    logic [MAX_LOG_COUNT-1:0] cnt;
    logic [MAX_LOG_COUNT:0] lim;
    logic [AXIS_TDATA_WIDTH-1:0] s1_data;
    logic [2*AXIS_TDATA_WIDTH-1:0] res;

    assign n_in = (EF_log_count > 5'(MAX_LOG_COUNT)) ? 5'(MAX_LOG_COUNT) : EF_log_count;
    assign chg = n_in != log_q;
    assign en = log_q != '0;
    assign acc = S_AXIS_tvalid & S_AXIS_tready;
    assign lim = (one << log_q) - one;
    assign is_first = cnt == '0;
    assign is_last = {1'b0, cnt} == lim;
    assign load = s2_done & (~M_AXIS_tvalid | M_AXIS_tready);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            S_AXIS_tready <= 1'b0;
            log_q         <= '0;
            cnt           <= '0;
            s1_v          <= 1'b0;
            s1_first      <= 1'b0;
            s1_last       <= 1'b0;
            s1_data       <= '0;
            s2_done       <= 1'b0;
            M_AXIS_tvalid <= 1'b0;
            M_AXIS_tdata  <= '0;
            overflow      <= 1'b0;
        end else begin
            S_AXIS_tready <= 1'b1;
            log_q         <= n_in;
            // a window-length change discards the partial window and the beat arriving with it
            if (chg || !en)
                cnt <= '0;
            else if (acc)
                cnt <= is_last ? '0 : cnt + 1'b1;
            s1_v <= acc & en & ~chg;
            if (acc) begin
                s1_data  <= S_AXIS_tdata;
                s1_first <= is_first;
                s1_last  <= is_last;
            end
            s2_done <= s1_v & s1_last;
            if (load) begin
                M_AXIS_tdata  <= res;
                M_AXIS_tvalid <= 1'b1;
            end else if (M_AXIS_tready) begin
                M_AXIS_tvalid <= 1'b0;
            end
            if (s2_done && !load)
                overflow <= 1'b1;
        end
    end

    for (genvar c = 0; c < CHANNEL_COUNT; c++) begin : g_lane
        logic signed [W-1:0] x, mx, mn, sa, sb;
        logic [W-1:0] d, pa;
        assign x  = s1_data[c*W +: W];
        // true difference is below 2^W, so the modulo-2^W subtraction is exact
        assign d  = mx - mn;
        assign sa = mx >>> EF_shift;
        assign sb = mn >>> EF_shift;
        assign pa = d >> EF_shift;
        assign res[(2*c+1)*W +: W] = EF_mode ? pa : sa;
        assign res[2*c*W +: W]     = EF_mode ? '0 : sb;
        always_ff @(posedge aclk or posedge areset) begin
            if (areset) begin
                mx <= '0;
                mn <= '0;
            end else if (s1_v) begin
                mx <= (s1_first || x > mx) ? x : mx;
                mn <= (s1_first || x < mn) ? x : mn;
            end
        end
    end
endmodule

// File: tb/tb_extremum_finder_mc.sv
// tb_extremum_finder_mc: scoreboard bench; a window-level reference model queues
// expected results and a monitor compares every delivered M_AXIS beat.
module tb_extremum_finder_mc;
    localparam int W = 16, C = 2, D = 32;

    logic aclk = 0, areset = 1;
    logic [4:0] EF_log_count = 5'd3;
    logic [2:0] EF_shift = 0;
    logic EF_mode = 0;
    logic [D-1:0] S_AXIS_tdata = 0;
    logic S_AXIS_tvalid = 0, S_AXIS_tready;
    logic [2*D-1:0] M_AXIS_tdata;
    logic M_AXIS_tvalid, M_AXIS_tready = 1, overflow;

    int n_cmp = 0, n_bad = 0;
    logic [2*D-1:0] exp_q[$];
    logic [D-1:0] win[$];
    bit bp_hold = 0, bp_got = 0;
    int s0[8] = '{-10, -30, -40, -20, 10, 20, 30, 40};

    extremum_finder_mc dut (
        .aclk(aclk), .areset(areset), .EF_log_count(EF_log_count), .EF_shift(EF_shift),
        .EF_mode(EF_mode), .S_AXIS_tdata(S_AXIS_tdata), .S_AXIS_tvalid(S_AXIS_tvalid),
        .S_AXIS_tready(S_AXIS_tready), .M_AXIS_tdata(M_AXIS_tdata),
        .M_AXIS_tvalid(M_AXIS_tvalid), .M_AXIS_tready(M_AXIS_tready), .overflow(overflow)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic logic [D-1:0] pk(input int a, input int b);
        logic [D-1:0] r;
        r = {b[15:0], a[15:0]};
        return r;
    endfunction

    function automatic logic [2*D-1:0] model_result();
        logic [2*D-1:0] r;
        int mx, mn, a, b, v;
        r = '0;
        for (int c = 0; c < C; c++) begin
            mx = -100000;
            mn = 100000;
            foreach (win[i]) begin
                v = $signed(win[i][c*W +: W]);
                if (v > mx) mx = v;
                if (v < mn) mn = v;
            end
            a = EF_mode ? (mx - mn) >> EF_shift : mx >>> EF_shift;
            b = EF_mode ? 0 : mn >>> EF_shift;
            r[(2*c+1)*W +: W] = a[W-1:0];
            r[2*c*W +: W] = b[W-1:0];
        end
        return r;
    endfunction

    function automatic int eff_n();
        return (EF_log_count > 20) ? 20 : int'(EF_log_count);
    endfunction

    task automatic beat(input bit v, input logic [D-1:0] d);
        S_AXIS_tvalid = v;
        S_AXIS_tdata = d;
        @(posedge aclk);
        #1;
        S_AXIS_tvalid = 0;
        if (v && EF_log_count != 0) begin
            win.push_back(d);
            if (win.size() == (1 << eff_n())) begin
                if (!bp_hold || !bp_got) exp_q.push_back(model_result());
                bp_got = bp_got | bp_hold;
                win.delete();
            end
        end
    endtask

    task automatic idle(input int k);
        repeat (k) beat(0, '0);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
        check("drain_outstanding", 64'(exp_q.size()), 0);
        exp_q.delete();
    endtask

    task automatic set_n(input int n);
        idle(2);
        EF_log_count = 5'(n);
        win.delete();
        idle(2);
    endtask

    task automatic send8(input bit gaps);
        for (int i = 0; i < 8; i++) begin
            if (gaps && i != 0) beat(0, '0);
            beat(1, pk(s0[i], 5));
        end
    endtask

    always @(negedge aclk) begin
        if (!areset && M_AXIS_tvalid && M_AXIS_tready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_result: got %h, expected no result", M_AXIS_tdata);
            end else begin
                check("result", M_AXIS_tdata, exp_q.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge aclk);
        #1;
        check("rst_s_tready", S_AXIS_tready, 0);
        check("rst_m_tvalid", M_AXIS_tvalid, 0);
        check("rst_m_tdata", M_AXIS_tdata, 0);
        check("rst_overflow", overflow, 0);
        areset = 0;
        idle(2);
        check("s_tready_after_rst", S_AXIS_tready, 1);

        // basic window, latency and single-cycle tvalid
        send8(0);
        idle(1);
        check("lat_k1_tvalid", M_AXIS_tvalid, 0);
        idle(1);
        check("lat_k2_tvalid", M_AXIS_tvalid, 1);
        check("minmax_tdata", M_AXIS_tdata, 64'h0005_0005_0028_FFD8);
        idle(1);
        check("tvalid_one_cycle", M_AXIS_tvalid, 0);

        // peak-to-peak with shift
        EF_mode = 1;
        EF_shift = 1;
        send8(0);
        idle(2);
        check("p2p_tdata", M_AXIS_tdata, 64'h0000_0000_0028_0000);
        idle(2);

        // tvalid gaps
        EF_mode = 0;
        EF_shift = 0;
        send8(1);
        idle(2);
        check("gaps_tdata", M_AXIS_tdata, 64'h0005_0005_0028_FFD8);
        drain();

        // full-scale peak-to-peak
        set_n(1);
        EF_mode = 1;
        beat(1, pk(32767, 0));
        beat(1, pk(-32768, 0));
        idle(2);
        check("p2p_fullscale", M_AXIS_tdata, 64'h0000_0000_FFFF_0000);
        drain();
        EF_mode = 0;

        // backpressure and overflow
        M_AXIS_tready = 0;
        bp_hold = 1;
        bp_got = 0;
        for (int i = 0; i < 6; i++) beat(1, 32'($urandom));
        idle(4);
        check("bp_tvalid_held", M_AXIS_tvalid, 1);
        check("bp_overflow", overflow, 1);
        check("bp_queued", 64'(exp_q.size()), 1);
        if (exp_q.size() != 0) check("bp_held_data", M_AXIS_tdata, exp_q[0]);
        bp_hold = 0;
        M_AXIS_tready = 1;
        idle(1);
        check("bp_tvalid_cleared", M_AXIS_tvalid, 0);
        beat(1, 32'($urandom));
        beat(1, 32'($urandom));
        drain();
        check("overflow_sticky", overflow, 1);

        // window-length change discards partial window
        set_n(3);
        for (int i = 0; i < 5; i++) beat(1, 32'($urandom));
        set_n(2);
        for (int i = 0; i < 4; i++) beat(1, 32'($urandom));
        drain();

        // reset mid-window
        set_n(3);
        for (int i = 0; i < 3; i++) beat(1, 32'($urandom));
        #2 areset = 1;
        #1;
        check("midrst_s_tready", S_AXIS_tready, 0);
        check("midrst_m_tvalid", M_AXIS_tvalid, 0);
        check("midrst_m_tdata", M_AXIS_tdata, 0);
        check("midrst_overflow", overflow, 0);
        win.delete();
        exp_q.delete();
        @(posedge aclk);
        #1 areset = 0;
        idle(2);
        for (int i = 0; i < 7; i++) beat(1, 32'($urandom));
        idle(4);
        check("midrst_no_early_result", M_AXIS_tvalid, 0);
        beat(1, 32'($urandom));
        drain();

        // randomized segments
        for (int seg = 0; seg < 40; seg++) begin
            int n;
            n = $urandom_range(0, 3);
            drain();
            EF_mode = 1'($urandom);
            EF_shift = 3'($urandom);
            if (n != int'(EF_log_count)) set_n(n);
            for (int i = $urandom_range(1, 20); i > 0; i--)
                beat($urandom_range(0, 9) < 7, 32'($urandom));
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
